// File: rtl/cpu_pkg.sv
// Shared definitions for the Hack-style multi-cycle control unit.
// Holds the control FSM state encoding and the bit positions of the
// instruction register fields (type, a-bit, comp, dest, jump).
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMRD,
    ST_EXEC,
    ST_WB
  } state_e;

  // Instruction word fields
  localparam int unsigned IR_CTYPE   = 15;  // 1 = C-instruction
  localparam int unsigned IR_ABIT    = 12;  // y operand: 1 = M, 0 = A
  localparam int unsigned IR_COMP_HI = 11;  // zx nx zy ny f no
  localparam int unsigned IR_COMP_LO = 6;

  // Destination bits
  localparam int unsigned DEST_A = 5;
  localparam int unsigned DEST_D = 4;
  localparam int unsigned DEST_M = 3;

  // Jump bits
  localparam int unsigned JMP_LT = 2;
  localparam int unsigned JMP_EQ = 1;
  localparam int unsigned JMP_GT = 0;

endpackage

// File: rtl/cpu_control_jump_eval.sv
// Combinational jump condition evaluator.
// Ports:
//   j_i[2:0]  jump field {lt, eq, gt}
//   zr_i      ALU result is zero
//   ng_i      ALU result is negative
//   taken_o   jump condition satisfied
module jump_eval
  import cpu_pkg::*;
(
  input  logic [2:0] j_i,
  input  logic       zr_i,
  input  logic       ng_i,
  output logic       taken_o
);

  assign taken_o = (j_i[JMP_LT] & ng_i)
                 | (j_i[JMP_EQ] & zr_i)
                 | (j_i[JMP_GT] & ~ng_i & ~zr_i);

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control unit for a 16-bit Hack-style datapath.
// Owns the A, D and PC registers, fetches over an instruction handshake,
// reads/writes data memory over a second handshake, drives the external
// combinational ALU and evaluates jumps.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req/addr/valid/data   instruction fetch handshake (addr = PC)
//   dmem_addr                  data address (A, or pre-EXEC A during WB)
//   dmem_re/rvalid/rdata       data read handshake
//   dmem_we/wdata/ack          data write handshake
//   alu_x, alu_y               ALU operands (D, and A or M)
//   alu_zx..alu_no             ALU control, non-zero only in EXEC
//   alu_out, alu_zr, alu_ng    ALU result and flags
//   pc_out, a_out, d_out       architectural register visibility
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] dmem_addr,
  output logic        dmem_re,
  input  logic        dmem_rvalid,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_we,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] pc_out,
  output logic [15:0] a_out,
  output logic [15:0] d_out
);

  state_e      state_q, state_d;
  logic [15:0] ir_q,   ir_d;
  logic [15:0] a_q,    a_d;
  logic [15:0] d_q,    d_d;
  logic [15:0] pc_q,   pc_d;
  logic [15:0] m_q,    m_d;
  logic [15:0] res_q,  res_d;   // ALU result captured for write-back
  logic [15:0] wba_q,  wba_d;   // A as it was before EXEC, used as WB address
  logic [15:0] pc_inc;
  logic        taken;

  assign pc_inc = pc_q + 16'd1;

  jump_eval u_jump_eval (
    .j_i    (ir_q[JMP_LT:JMP_GT]),
    .zr_i   (alu_zr),
    .ng_i   (alu_ng),
    .taken_o(taken)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    m_d     = m_q;
    res_d   = res_q;
    wba_d   = wba_q;
    imem_req = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = '0;

    unique case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!ir_q[IR_CTYPE]) begin
          a_d     = {1'b0, ir_q[14:0]};
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else if (ir_q[IR_ABIT]) begin
          state_d = ST_MEMRD;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEMRD: begin
        dmem_re = 1'b1;
        if (dmem_rvalid) begin
          m_d     = dmem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[IR_COMP_HI:IR_COMP_LO];
        res_d = alu_out;
        wba_d = a_q;
        if (ir_q[DEST_D]) d_d = alu_out;
        if (ir_q[DEST_A]) a_d = alu_out;
        // Jump target is the A value before this instruction's A write.
        pc_d    = taken ? a_q : pc_inc;
        state_d = ir_q[DEST_M] ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        dmem_we = 1'b1;
        if (dmem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Requests are suppressed while reset is held so no handshake can
    // complete into a context that is being discarded.
    if (reset) begin
      imem_req = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= RESET_PC;
      m_q     <= '0;
      res_q   <= '0;
      wba_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      m_q     <= m_d;
      res_q   <= res_d;
      wba_q   <= wba_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = (state_q == ST_WB) ? wba_q : a_q;
  assign dmem_wdata = res_q;
  assign alu_x      = d_q;
  assign alu_y      = ir_q[IR_ABIT] ? m_q : a_q;
  assign pc_out     = pc_q;
  assign a_out      = a_q;
  assign d_out      = d_q;

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_valid;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] dmem_addr, dmem_rdata, dmem_wdata;
  logic        dmem_re, dmem_rvalid, dmem_we, dmem_ack;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [15:0] pc_out, a_out, d_out;
  logic [5:0]  alu_ctl;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [256];
  logic [31:0] wq [$];   // expected writes {addr, data}

  always #5 clk = ~clk;

  cpu_control #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc_out(pc_out), .a_out(a_out), .d_out(d_out)
  );

  assign alu_ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

  // Hack ALU model
  logic [15:0] bx, by, bo;
  always_comb begin
    bx = alu_zx ? 16'h0000 : alu_x;
    if (alu_nx) bx = ~bx;
    by = alu_zy ? 16'h0000 : alu_y;
    if (alu_ny) by = ~by;
    bo = alu_f ? (bx + by) : (bx & by);
    if (alu_no) bo = ~bo;
  end
  assign alu_out = bo;
  assign alu_zr  = (bo == 16'h0000);
  assign alu_ng  = bo[15];

  // Runs one instruction from FETCH back to FETCH, acting as both memories.
  // Writes are popped from the scoreboard and compared as they are acked.
  task automatic run_instr(input logic [15:0] instr, input int idly, input int rdly, input int adly,
                           output int cycles, output logic [5:0] ctl,
                           output int we_cycles, output logic we_stable);
    int ic, rc, ac;
    logic fetched, done;
    logic [15:0] wa0, wd0;
    logic [31:0] exp;
    cycles = 0; ic = 0; rc = 0; ac = 0; fetched = 0; done = 0;
    we_cycles = 0; we_stable = 1'b1; ctl = '0; wa0 = '0; wd0 = '0;
    for (int n = 0; n < 60 && !done; n++) begin
      imem_valid = 1'b0; dmem_rvalid = 1'b0; dmem_ack = 1'b0;
      if (alu_ctl != 6'b0) ctl = alu_ctl;
      if (imem_req && !fetched) begin
        if (ic == idly) begin
          imem_valid = 1'b1; imem_data = instr; fetched = 1'b1;
        end else ic++;
      end
      if (dmem_re) begin
        if (rc == rdly) begin
          dmem_rvalid = 1'b1; dmem_rdata = ram[dmem_addr[7:0]];
        end else rc++;
      end
      if (dmem_we) begin
        if (we_cycles == 0) begin
          wa0 = dmem_addr; wd0 = dmem_wdata;
        end else if (dmem_addr !== wa0 || dmem_wdata !== wd0) we_stable = 1'b0;
        we_cycles++;
        if (ac == adly) begin
          dmem_ack = 1'b1;
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%h data=%h, required no write", dmem_addr, dmem_wdata);
          end else begin
            exp = wq.pop_front();
            if ({dmem_addr, dmem_wdata} !== exp) begin
              errors++;
              $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                       dmem_addr, dmem_wdata, exp[31:16], exp[15:0]);
            end
          end
          ram[dmem_addr[7:0]] = dmem_wdata;
        end else ac++;
      end
      @(posedge clk); #1;
      cycles++;
      if (fetched && imem_req) done = 1'b1;
    end
    imem_valid = 1'b0; dmem_rvalid = 1'b0; dmem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: instr %h did not return to fetch within 60 cycles", instr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b required 0", imem_req); end
    checks++; if (dmem_re !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL rst_dmem_req: got re=%b we=%b required 0 0", dmem_re, dmem_we); end
    checks++; if (pc_out !== RST_PC || imem_addr !== RST_PC) begin errors++; $display("FAIL rst_pc: got pc=%h addr=%h required %h", pc_out, imem_addr, RST_PC); end
    checks++; if (a_out !== 16'h0 || d_out !== 16'h0 || dmem_addr !== 16'h0) begin errors++; $display("FAIL rst_ad: got a=%h d=%h daddr=%h required 0", a_out, d_out, dmem_addr); end
    checks++; if (alu_ctl !== 6'b0 || alu_x !== 16'h0 || alu_y !== 16'h0 || dmem_wdata !== 16'h0) begin errors++; $display("FAIL rst_alu: got ctl=%b x=%h y=%h wdata=%h required 0", alu_ctl, alu_x, alu_y, dmem_wdata); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_fetch_start: got imem_req=%b required 1", imem_req); end
  endtask

  task automatic test_a_instr();
    int cyc, wc; logic [5:0] ctl; logic st;
    run_instr(16'h0005, 0, 0, 0, cyc, ctl, wc, st);
    checks++; if (a_out !== 16'h0005) begin errors++; $display("FAIL a_instr_a: got %h required 0005", a_out); end
    checks++; if (pc_out !== 16'h0001) begin errors++; $display("FAIL a_instr_pc: got %h required 0001", pc_out); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL a_instr_cycles: got %0d required 2", cyc); end
  endtask

  task automatic test_c_dest_d();
    int cyc, wc; logic [5:0] ctl; logic st;
    run_instr(16'hEC10, 0, 0, 0, cyc, ctl, wc, st);     // D=A
    checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL c_d_ctl: got %b required 110000", ctl); end
    checks++; if (d_out !== 16'h0005) begin errors++; $display("FAIL c_d_d: got %h required 0005", d_out); end
    checks++; if (pc_out !== 16'h0002) begin errors++; $display("FAIL c_d_pc: got %h required 0002", pc_out); end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL c_d_cycles: got %0d required 3", cyc); end
  endtask

  task automatic test_mem_rmw();
    int cyc, wc; logic [5:0] ctl; logic st;
    ram[8'h10] = 16'h0007;
    run_instr(16'h0010, 0, 0, 0, cyc, ctl, wc, st);
    wq.push_back({16'h0010, 16'h0008});
    run_instr(16'hFDD8, 0, 0, 0, cyc, ctl, wc, st);     // MD=M+1
    checks++; if (d_out !== 16'h0008) begin errors++; $display("FAIL rmw_d: got %h required 0008", d_out); end
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL rmw_pc: got %h required 0004", pc_out); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL rmw_cycles: got %0d required 5", cyc); end
    checks++; if (wq.size() !== 0) begin errors++; $display("FAIL rmw_write_missing: got %0d pending required 0", wq.size()); end
  endtask

  task automatic test_jump();
    int cyc, wc; logic [5:0] ctl; logic st;
    run_instr(16'h0000, 0, 0, 0, cyc, ctl, wc, st);
    run_instr(16'hEC10, 0, 0, 0, cyc, ctl, wc, st);     // D=A -> 0
    run_instr(16'h0020, 0, 0, 0, cyc, ctl, wc, st);
    run_instr(16'hEA87, 0, 0, 0, cyc, ctl, wc, st);     // 0;JMP
    checks++; if (pc_out !== 16'h0020) begin errors++; $display("FAIL jmp_pc: got %h required 0020", pc_out); end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL jmp_cycles: got %0d required 3", cyc); end
    run_instr(16'hEE90, 0, 0, 0, cyc, ctl, wc, st);     // D=-1
    checks++; if (d_out !== 16'hFFFF) begin errors++; $display("FAIL jmp_dneg: got %h required ffff", d_out); end
    run_instr(16'hE301, 0, 0, 0, cyc, ctl, wc, st);     // D;JGT not taken
    checks++; if (pc_out !== 16'h0022) begin errors++; $display("FAIL jgt_pc: got %h required 0022", pc_out); end
    run_instr(16'hE304, 0, 0, 0, cyc, ctl, wc, st);     // D;JLT taken
    checks++; if (pc_out !== 16'h0020) begin errors++; $display("FAIL jlt_pc: got %h required 0020", pc_out); end
  endtask

  task automatic test_am_wait();
    int cyc, wc; logic [5:0] ctl; logic st;
    ram[8'h30] = 16'h0031;
    run_instr(16'h0030, 0, 0, 0, cyc, ctl, wc, st);
    wq.push_back({16'h0030, 16'h0030});
    run_instr(16'hFCA8, 0, 0, 3, cyc, ctl, wc, st);     // AM=M-1
    checks++; if (a_out !== 16'h0030) begin errors++; $display("FAIL am_a: got %h required 0030", a_out); end
    checks++; if (d_out !== 16'hFFFF) begin errors++; $display("FAIL am_d_kept: got %h required ffff", d_out); end
    checks++; if (wc !== 4) begin errors++; $display("FAIL am_we_cycles: got %0d required 4", wc); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL am_we_stable: got %b required 1", st); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL am_cycles: got %0d required 8", cyc); end
    checks++; if (wq.size() !== 0) begin errors++; $display("FAIL am_write_missing: got %0d pending required 0", wq.size()); end
  endtask

  task automatic test_waits();
    int cyc, wc; logic [5:0] ctl; logic st;
    run_instr(16'hFC10, 2, 1, 0, cyc, ctl, wc, st);     // D=M, slow fetch and read
    checks++; if (d_out !== 16'h0030) begin errors++; $display("FAIL wait_d: got %h required 0030", d_out); end
    checks++; if (cyc !== 7) begin errors++; $display("FAIL wait_cycles: got %0d required 7", cyc); end
    checks++; if (pc_out !== 16'h0023) begin errors++; $display("FAIL wait_pc: got %h required 0023", pc_out); end
  endtask

  task automatic test_reset_mid_memrd();
    int cyc, wc; logic [5:0] ctl; logic st;
    imem_valid = 1'b1; imem_data = 16'hFC10;            // D=M
    @(posedge clk); #1;
    imem_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (dmem_re !== 1'b1) begin errors++; $display("FAIL mid_re_up: got %b required 1", dmem_re); end
    @(posedge clk); #1;                                 // one wait cycle, no rvalid
    reset = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 16'h1234;
    @(posedge clk); #1;
    checks++; if (dmem_re !== 1'b0) begin errors++; $display("FAIL mid_re_drop: got %b required 0", dmem_re); end
    checks++; if (d_out !== 16'h0000) begin errors++; $display("FAIL mid_d: got %h required 0000", d_out); end
    reset = 1'b0; dmem_rvalid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL mid_refetch: got req=%b addr=%h required 1 %h", imem_req, imem_addr, RST_PC); end
    run_instr(16'h0005, 0, 0, 0, cyc, ctl, wc, st);
    checks++; if (pc_out !== RST_PC + 16'd1 || a_out !== 16'h0005) begin errors++; $display("FAIL mid_after: got pc=%h a=%h required %h 0005", pc_out, a_out, RST_PC + 16'd1); end
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_data = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    test_reset();
    test_a_instr();
    test_c_dest_d();
    test_mem_rmw();
    test_jump();
    test_am_wait();
    test_waits();
    test_reset_mid_memrd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
